// File: rtl/sram_arb_pkg.sv
// Shared definitions for the SRAM command arbiter: state encoding, default
// widths and the index-width helper used for requester indices.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  localparam int ADDR_W_DEF = 19;
  localparam int DATA_W_DEF = 8;

  // Width of a requester index; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sram_rr_pick.sv
// Combinational round-robin picker: first set request strictly after ptr,
// wrapping modulo NREQ (NREQ need not be a power of two).
module sram_rr_pick
  import sram_arb_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]         req,
  input  logic [idx_w(NREQ)-1:0]  ptr,
  output logic                    valid,
  output logic [idx_w(NREQ)-1:0]  idx
);

  localparam int IW = idx_w(NREQ);
  localparam logic [IW:0] NREQ_V = (IW+1)'(NREQ);

  logic [2*NREQ-1:0] dbl;
  logic [2*NREQ-1:0] shifted;
  logic [NREQ-1:0]   rot;
  logic [NREQ-1:0]   lowest;
  logic [IW:0]       start;
  logic [IW:0]       sum;
  logic [IW-1:0]     off_acc [NREQ+1];

  // Rotate so bit 0 is requester ptr+1; the doubled vector makes the wrap free.
  assign start   = {1'b0, ptr} + {{IW{1'b0}}, 1'b1};
  assign dbl     = {req, req};
  assign shifted = dbl >> start;
  assign rot     = shifted[NREQ-1:0];
  assign lowest  = rot & (~rot + NREQ'(1'b1));

  assign off_acc[0] = '0;
  for (genvar j = 0; j < NREQ; j++) begin : g_enc
    assign off_acc[j+1] = off_acc[j] | (lowest[j] ? IW'(j) : {IW{1'b0}});
  end

  // sum < 2*NREQ, so a single conditional subtract finishes the modulo.
  assign sum   = start + {1'b0, off_acc[NREQ]};
  assign valid = |req;
  assign idx   = (sum >= NREQ_V) ? IW'(sum - NREQ_V) : sum[IW-1:0];

endmodule

// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one sram_ctrl command port between NREQ
// requesters; latches the winner's command and returns data plus a one-cycle ack.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          req_rw,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_wdata,
  output logic [NREQ-1:0]          ack,
  output logic [DATA_W-1:0]        rdata,
  output logic [idx_w(NREQ)-1:0]   gnt_idx,
  output logic                     busy,
  output logic                     mem,
  output logic                     rw,
  output logic [ADDR_W-1:0]        addr,
  output logic [DATA_W-1:0]        data_f2s,
  input  logic                     ready,
  input  logic [DATA_W-1:0]        data_s2f_r
);

  localparam int IW = idx_w(NREQ);
  localparam logic [IW-1:0]   PTR_RST = IW'(NREQ - 1);
  localparam logic [NREQ-1:0] ACK_ONE = NREQ'(1'b1);

  arb_state_t      state;
  arb_state_t      state_nxt;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   pick_idx;
  logic            pick_valid;
  logic            seen_low;

  logic [ADDR_W-1:0] addr_arr  [NREQ];
  logic [DATA_W-1:0] wdata_arr [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign addr_arr[i]  = req_addr[i*ADDR_W +: ADDR_W];
    assign wdata_arr[i] = req_wdata[i*DATA_W +: DATA_W];
  end

  sram_rr_pick #(.NREQ(NREQ)) u_pick (
    .req   (req),
    .ptr   (ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // Next-state logic; req is only looked at while IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (pick_valid) state_nxt = ISSUE;
        else            state_nxt = IDLE;
      end
      ISSUE: begin
        if (ready) state_nxt = BUSY;
        else       state_nxt = ISSUE;
      end
      BUSY: begin
        if (ready && seen_low) state_nxt = DONE;
        else                   state_nxt = BUSY;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, command registers, pointer and read-data capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      ptr      <= PTR_RST;
      gnt_idx  <= '0;
      rw       <= 1'b1;
      addr     <= '0;
      data_f2s <= '0;
      rdata    <= '0;
      seen_low <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            gnt_idx  <= pick_idx;
            rw       <= req_rw[pick_idx];
            addr     <= addr_arr[pick_idx];
            data_f2s <= wdata_arr[pick_idx];
          end
        end
        ISSUE: begin
          if (ready) seen_low <= 1'b0;
        end
        BUSY: begin
          // The controller must drop ready before its return to ready means "done".
          if (!ready) seen_low <= 1'b1;
          if (ready && seen_low) begin
            ptr <= gnt_idx;
            if (rw) rdata <= data_s2f_r;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem  = (state == ISSUE);
  assign busy = (state != IDLE);
  assign ack  = (state == DONE) ? (ACK_ONE << gnt_idx) : {NREQ{1'b0}};

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed self-checking bench for sram_arbiter with a small sram_ctrl model
// (2-requester instance) plus a 3-requester instance for wrap-around checks.
module tb_sram_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // NREQ=2 instance
  logic [1:0]   req = 2'b00, req_rw = 2'b00, ack;
  logic [37:0]  req_addr = 38'd0;
  logic [15:0]  req_wdata = 16'd0;
  logic [7:0]   rdata, data_f2s, data_s2f_r = 8'h00;
  logic [0:0]   gnt_idx;
  logic         busy, mem, rw, ready;
  logic [18:0]  addr;

  sram_arbiter #(.NREQ(2)) dut (
    .clk(clk), .reset(reset), .req(req), .req_rw(req_rw), .req_addr(req_addr),
    .req_wdata(req_wdata), .ack(ack), .rdata(rdata), .gnt_idx(gnt_idx), .busy(busy),
    .mem(mem), .rw(rw), .addr(addr), .data_f2s(data_f2s), .ready(ready),
    .data_s2f_r(data_s2f_r)
  );

  // NREQ=3 instance
  logic [2:0]   req3 = 3'b000, req_rw3 = 3'b000, ack3;
  logic [56:0]  req_addr3 = 57'd0;
  logic [23:0]  req_wdata3 = 24'd0;
  logic [7:0]   rdata3, data_f2s3;
  logic [7:0]   data_s2f_r3 = 8'h00;
  logic [1:0]   gnt_idx3;
  logic         busy3, mem3, rw3, ready3;
  logic [18:0]  addr3;

  sram_arbiter #(.NREQ(3)) dut3 (
    .clk(clk), .reset(reset), .req(req3), .req_rw(req_rw3), .req_addr(req_addr3),
    .req_wdata(req_wdata3), .ack(ack3), .rdata(rdata3), .gnt_idx(gnt_idx3), .busy(busy3),
    .mem(mem3), .rw(rw3), .addr(addr3), .data_f2s(data_f2s3), .ready(ready3),
    .data_s2f_r(data_s2f_r3)
  );

  // sram_ctrl model: accepts on mem&&ready, then ready low two cycles.
  logic [1:0] cnt = 2'd0, cnt3 = 2'd0;
  int         stall_cfg = 0;
  int         stall_cnt = 0;
  int         accepts = 0;
  logic [7:0] sram_q [16];

  assign ready  = (cnt == 2'd0) && !(mem && (stall_cnt < stall_cfg));
  assign ready3 = (cnt3 == 2'd0);

  always @(posedge clk) begin
    if (reset) begin
      cnt       <= 2'd0;
      stall_cnt <= 0;
    end else if (mem && ready) begin
      cnt       <= 2'd2;
      stall_cnt <= 0;
      accepts   <= accepts + 1;
      if (rw) data_s2f_r <= sram_q[addr[3:0]];
      else    sram_q[addr[3:0]] <= data_f2s;
    end else begin
      if (cnt != 2'd0) cnt <= cnt - 2'd1;
      if (mem && (stall_cnt < stall_cfg)) stall_cnt <= stall_cnt + 1;
    end
  end

  always @(posedge clk) begin
    if (reset)               cnt3 <= 2'd0;
    else if (mem3 && ready3) cnt3 <= 2'd2;
    else if (cnt3 != 2'd0)   cnt3 <= cnt3 - 2'd1;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for a nonzero ack on instance sel; n = cycles waited.
  task automatic wait_ack(input int sel, output logic [2:0] a, output int n);
    logic [2:0] obs;
    a = 3'b000;
    n = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      n++;
      obs = (sel == 0) ? {1'b0, ack} : ack3;
      if (obs != 3'b000) begin
        a = obs;
        break;
      end
    end
    if (a == 3'b000) check("ack_timeout", {29'd0, a}, 32'd1);
  endtask

  logic [2:0] a;
  int         n;
  int         acc0;
  int         ack_seen;
  logic [1:0] exp_seq [4] = '{2'b01, 2'b10, 2'b01, 2'b10};

  initial begin
    repeat (3) tick();
    check("rst_mem", {31'd0, mem}, 32'd0);
    check("rst_rw", {31'd0, rw}, 32'd1);
    check("rst_addr", {13'd0, addr}, 32'd0);
    check("rst_data_f2s", {24'd0, data_f2s}, 32'd0);
    check("rst_ack", {30'd0, ack}, 32'd0);
    check("rst_rdata", {24'd0, rdata}, 32'd0);
    check("rst_gnt", {31'd0, gnt_idx}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    tick();

    // T1: requester 0 writes 0xA5 to 0x12345
    req = 2'b01; req_rw = 2'b00;
    req_addr[0 +: 19] = 19'h12345; req_wdata[0 +: 8] = 8'hA5;
    check("t1_busy_c0", {31'd0, busy}, 32'd0);
    for (int c = 1; c <= 6; c++) begin
      tick();
      check($sformatf("t1_mem_c%0d", c), {31'd0, mem}, (c == 1) ? 32'd1 : 32'd0);
      check($sformatf("t1_ack_c%0d", c), {30'd0, ack}, (c == 5) ? 32'd1 : 32'd0);
      if (c == 1) begin
        check("t1_rw", {31'd0, rw}, 32'd0);
        check("t1_addr", {13'd0, addr}, 32'h12345);
        check("t1_data_f2s", {24'd0, data_f2s}, 32'hA5);
        check("t1_gnt", {31'd0, gnt_idx}, 32'd0);
      end
      if (c != 5) check($sformatf("t1_busy_c%0d", c), {31'd0, busy}, (c <= 4) ? 32'd1 : 32'd0);
      if (c == 5) req = 2'b00;
    end

    // T2: requester 1 reads back 0x12345
    req = 2'b10; req_rw = 2'b10; req_addr[19 +: 19] = 19'h12345;
    wait_ack(0, a, n);
    check("t2_ack", {29'd0, a}, 32'd2);
    check("t2_latency", n, 32'd5);
    check("t2_rdata", {24'd0, rdata}, 32'hA5);
    check("t2_gnt", {31'd0, gnt_idx}, 32'd1);
    req = 2'b00;
    tick(); tick();
    check("t2_rdata_hold", {24'd0, rdata}, 32'hA5);

    // T3: both requesting continuously -> strict alternation, 6-cycle spacing
    req = 2'b11; req_rw = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_ack(0, a, n);
      check($sformatf("t3_ack%0d", k), {29'd0, a}, {30'd0, exp_seq[k]});
      check($sformatf("t3_gnt%0d", k), {31'd0, gnt_idx}, (k % 2 == 0) ? 32'd0 : 32'd1);
      check($sformatf("t3_gap%0d", k), n, (k == 0) ? 32'd5 : 32'd6);
    end
    req = 2'b00;
    tick();

    // T4: controller stalls ready for 3 ISSUE cycles
    req = 2'b01; req_rw = 2'b00; req_addr[0 +: 19] = 19'h00003; req_wdata[0 +: 8] = 8'h5C;
    stall_cfg = 3;
    acc0 = accepts;
    for (int c = 1; c <= 8; c++) begin
      tick();
      check($sformatf("t4_mem_c%0d", c), {31'd0, mem}, (c <= 4) ? 32'd1 : 32'd0);
      check($sformatf("t4_ack_c%0d", c), {30'd0, ack}, (c == 8) ? 32'd1 : 32'd0);
    end
    check("t4_accepts", accepts - acc0, 32'd1);
    req = 2'b00; stall_cfg = 0;
    tick();

    // T5: reset during BUSY aborts without ack
    req = 2'b10; req_rw = 2'b10; req_addr[19 +: 19] = 19'h12345;
    tick(); tick();
    check("t5_busy_pre", {31'd0, busy}, 32'd1);
    reset = 1'b1; req = 2'b00;
    tick();
    check("t5_busy", {31'd0, busy}, 32'd0);
    check("t5_mem", {31'd0, mem}, 32'd0);
    check("t5_ack", {30'd0, ack}, 32'd0);
    reset = 1'b0;
    ack_seen = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (ack != 2'b00) ack_seen++;
    end
    check("t5_no_ack", ack_seen, 32'd0);
    req = 2'b10;
    wait_ack(0, a, n);
    check("t5_ack_after", {29'd0, a}, 32'd2);
    check("t5_latency", n, 32'd5);
    check("t5_rdata", {24'd0, rdata}, 32'hA5);
    req = 2'b00;

    // T6: NREQ=3 wrap-around
    req3 = 3'b100; req_rw3 = 3'b111;
    wait_ack(1, a, n);
    check("t6_ack_a", {29'd0, a}, 32'd4);
    check("t6_gnt_a", {30'd0, gnt_idx3}, 32'd2);
    req3 = 3'b101;
    wait_ack(1, a, n);
    check("t6_ack_wrap", {29'd0, a}, 32'd1);
    check("t6_gnt_wrap", {30'd0, gnt_idx3}, 32'd0);
    wait_ack(1, a, n);
    check("t6_ack_next", {29'd0, a}, 32'd4);
    check("t6_gnt_next", {30'd0, gnt_idx3}, 32'd2);
    check("t6_gap", n, 32'd6);
    req3 = 3'b000;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
